// File: rtl/ps2_rx_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_rx_frontend
// Purpose  : PS/2 device-to-host line receiver. Synchronises and deglitches
//            the raw ps2_clk/ps2_data pins, deserialises 11-bit frames
//            (start, 8 data LSB first, odd parity, stop) and queues the
//            accepted scancodes in a first-word-fall-through FIFO.
// Ports    : clk50     - 50 MHz system clock
//            reset_n   - asynchronous active-low reset
//            ps2_clk   - raw PS/2 clock pin
//            ps2_data  - raw PS/2 data pin
//            dat_o     - scancode at FIFO head (0 while empty)
//            perr_o    - parity-error flag stored with the head entry
//            valid_o   - FIFO not empty
//            rd_i      - pop head on rising clk50 while valid_o=1
//            count_o   - FIFO occupancy, 0 .. 2**DEPTH_LOG2
//            ovf_o     - sticky: a frame was lost because the FIFO was full
//            clr_i     - synchronous clear of ovf_o (a same-cycle set wins)
//            ferr_o    - one-cycle pulse when a frame is discarded
// Options  : PS2_RX_PARERR_DROP_EN - when defined, parity-errored frames are
//            discarded with an ferr_o pulse and perr_o is constant 0.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_frontend #(
    parameter int FILTER     = 8,
    parameter int TIMEOUT    = 50000,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk50,
    input  logic                  reset_n,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    output logic [7:0]            dat_o,
    output logic                  perr_o,
    output logic                  valid_o,
    input  logic                  rd_i,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  ovf_o,
    input  logic                  clr_i,
    output logic                  ferr_o
);

    localparam int               c_DEPTH     = 1 << DEPTH_LOG2;
    localparam int               c_TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [7:0]       c_FILT_LAST = 8'(FILTER - 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
    localparam logic [DEPTH_LOG2:0] c_FULL   = (DEPTH_LOG2 + 1)'(c_DEPTH);

    // ------------------------------------------------------------------
    // Input conditioning: bit 0 = ps2_clk, bit 1 = ps2_data.
    // Each line: 2-FF synchroniser, then a level filter that only follows
    // the synchronised input once it has differed for FILTER consecutive
    // cycles. Both lines see identical latency, so data stays aligned
    // with the filtered clock edge.
    // ------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {ps2_data, ps2_clk};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_line
            logic       r_s1;
            logic       r_s2;
            logic       r_filt;
            logic [7:0] r_cnt;

            always_ff @(posedge clk50 or negedge reset_n) begin
                if (!reset_n) begin
                    r_s1   <= 1'b1;
                    r_s2   <= 1'b1;
                    r_filt <= 1'b1;
                    r_cnt  <= 8'd0;
                end else begin
                    r_s1 <= w_raw[i];
                    r_s2 <= r_s1;
                    if (r_s2 != r_filt) begin
                        // r_cnt holds the number of earlier disagreeing
                        // cycles; this is the FILTER-th one.
                        if (r_cnt == c_FILT_LAST) begin
                            r_filt <= r_s2;
                            r_cnt  <= 8'd0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end else begin
                        r_cnt <= 8'd0;
                    end
                end
            end

            assign w_filt[i] = r_filt;
        end
    endgenerate

    logic r_clk_filt_d;
    logic w_fall;
    logic w_data;

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_filt_d <= 1'b1;
        end else begin
            r_clk_filt_d <= w_filt[0];
        end
    end

    assign w_fall = r_clk_filt_d & ~w_filt[0];
    assign w_data = w_filt[1];

    // ------------------------------------------------------------------
    // Frame deserialiser
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_bit_idx;
    logic [2:0]          w_bit_idx_nxt;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_nxt;
    logic                r_perr;
    logic                w_perr_nxt;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [c_TO_W-1:0]   w_to_cnt_nxt;
    logic                r_push;
    logic                w_push_nxt;
    logic [8:0]          r_push_entry;
    logic [8:0]          w_push_entry;
    logic                r_ferr;
    logic                w_ferr_nxt;

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'd0;
            r_perr       <= 1'b0;
            r_to_cnt     <= '0;
            r_push       <= 1'b0;
            r_push_entry <= 9'd0;
            r_ferr       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_perr    <= w_perr_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_push    <= w_push_nxt;
            r_ferr    <= w_ferr_nxt;
            if (w_push_nxt) begin
                r_push_entry <= w_push_entry;
            end
        end
    end

`ifdef PS2_RX_PARERR_DROP_EN
    assign w_push_entry = {1'b0, r_shift};
`else
    assign w_push_entry = {r_perr, r_shift};
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_perr_nxt    = r_perr;
        w_push_nxt    = 1'b0;
        w_ferr_nxt    = 1'b0;

        // Inactivity counter runs only inside a frame and restarts on
        // every received clock edge.
        if (r_state == S_IDLE || w_fall) begin
            w_to_cnt_nxt = '0;
        end else begin
            w_to_cnt_nxt = r_to_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                // A fall with data high is a stray edge and is ignored.
                if (w_fall && !w_data) begin
                    w_state_nxt   = S_DATA;
                    w_bit_idx_nxt = 3'd0;
                end
            end
            S_DATA: begin
                if (w_fall) begin
                    w_shift_nxt   = {w_data, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (w_fall) begin
                    // Odd parity: data bits plus parity bit must hold an
                    // odd number of ones.
                    w_perr_nxt  = ~(^r_shift ^ w_data);
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    w_state_nxt = S_IDLE;
                    if (!w_data) begin
                        w_ferr_nxt = 1'b1;
`ifdef PS2_RX_PARERR_DROP_EN
                    end else if (r_perr) begin
                        w_ferr_nxt = 1'b1;
`endif
                    end else begin
                        w_push_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A received edge takes precedence over an expiring timeout.
        if (r_state != S_IDLE && !w_fall && r_to_cnt == c_TO_LAST) begin
            w_state_nxt  = S_IDLE;
            w_ferr_nxt   = 1'b1;
            w_to_cnt_nxt = '0;
        end
    end

    assign ferr_o = r_ferr;

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [8:0]            r_mem [0:c_DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_ovf;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_drop;
    logic [8:0]            w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = rd_i && !w_empty;
    // When full, a write is only possible because a pop frees a slot in
    // the same cycle.
    assign w_wr    = r_push && (!w_full || w_pop);
    assign w_drop  = r_push && w_full && !w_pop;

    always_ff @(posedge clk50) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_push_entry;
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Head is forced to zero while empty so the outputs never expose
    // stale or uninitialised storage.
    assign w_head  = w_empty ? 9'd0 : r_mem[r_rd_ptr];
    assign dat_o   = w_head[7:0];
    assign perr_o  = w_head[8];
    assign valid_o = !w_empty;
    assign count_o = r_count;
    assign ovf_o   = r_ovf;

endmodule

`default_nettype wire

// File: doc/ps2_rx_frontend.md
Name: ps2_rx_frontend

Overview:
PS/2 line receiver placed between the keyboard connector pins and the terminal's PS/2 keyboard controller. It synchronises and deglitches ps2_clk/ps2_data, deserialises 11-bit device-to-host frames, and checks start, odd parity and stop bits. Accepted scancodes go into a first-word-fall-through FIFO, and the controller drains them with a valid/read handshake. There is no host-to-device transmit path: both lines are inputs only.

Parameters:
FILTER, 8, number of consecutive clk50 cycles a synchronised line must hold a new level before the filtered level changes (1..255)
TIMEOUT, 50000, clk50 cycles without a filtered ps2_clk falling edge before a partial frame is abandoned (1 ms at 50 MHz)
DEPTH_LOG2, 3, log2 of FIFO depth in entries (default 8 entries)

Ports:
clk50  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock from pin
ps2_data  in  1  raw PS/2 data from pin
dat_o  out  8  scancode at FIFO head; valid only while valid_o=1
perr_o  out  1  parity-error flag stored with the head entry
valid_o  out  1  FIFO not empty
rd_i  in  1  pop head on rising clk50 when valid_o=1
count_o  out  DEPTH_LOG2+1  FIFO occupancy
ovf_o  out  1  sticky overflow: a frame was lost because the FIFO was full
clr_i  in  1  synchronous clear of ovf_o
ferr_o  out  1  one-cycle pulse when a frame is discarded (bad stop bit or timeout)

Behaviour:
- Reset (async, reset_n=0): synchroniser and filtered levels = 1; FIFO empty; count_o=0; valid_o=0; dat_o=0; perr_o=0; ovf_o=0; ferr_o=0; FSM in IDLE; timeout counter = 0.
- Input path: 2-FF synchroniser per line, then the FILTER stability counter. The filtered ps2_clk falling edge (fall) is a one-cycle strobe. Data is sampled from filtered ps2_data on that same cycle.
- FSM states:
  - IDLE: on fall with data=0 (start bit), go to DATA with bit index 0. On fall with data=1, stay in IDLE (spurious edge, no error).
  - DATA: on fall, shift the bit in LSB first and increment the index; after the 8th bit go to PARITY.
  - PARITY: on fall, latch the parity bit; perr = ~(^data ^ parity), i.e. odd parity required; go to STOP.
  - STOP: on fall with data=1, push {perr, data} into the FIFO and go to IDLE. On fall with data=0, pulse ferr_o, discard the frame, go to IDLE.
- Timeout: in any state other than IDLE, the counter increments every cycle and clears on each fall. When it reaches TIMEOUT-1, pulse ferr_o, discard the frame, go to IDLE. The counter is held at 0 while in IDLE.
- FIFO:
  - Push takes effect on the cycle after the STOP-state fall. valid_o rises one cycle after the push; dat_o/perr_o show the head combinationally from the registered read pointer.
  - rd_i while empty is ignored.
  - Push while full with no simultaneous pop: the frame is dropped, ovf_o is set, and contents are unchanged.
  - Push and pop in the same cycle while full: both happen and ovf_o is not set.
  - Push and pop in the same cycle while empty: no pop occurs, and the push lands.
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth. count_o is exact from 0 to 2^DEPTH_LOG2.
- ovf_o: clr_i clears it. If a set and clr_i occur in the same cycle, set wins.
- Reset asserted mid-frame or mid-read: everything returns to reset values immediately; no partial frame survives.

Optional Feature:
PS2_RX_PARERR_DROP_EN
- Defined: frames with a parity error are not pushed. ferr_o pulses instead, and perr_o is tied to 0.
- Undefined: parity-errored frames are stored with perr_o=1, as described above.

Test Plan:
- Clean frame, 0x1C, correct odd parity (p=0), 30 µs half-period → one push; valid_o=1, dat_o=0x1C, perr_o=0, count_o=1; rd_i pulse → valid_o=0, count_o=0.
- Frame 0x1C sent with parity bit 1 → macro undefined: dat_o=0x1C, perr_o=1. Macro defined: nothing stored, ferr_o pulses once.
- 3 clean data bits, then the lines are held high for 1.2 ms, then a clean frame 0xF0 → ferr_o pulses once at the timeout; then dat_o=0xF0, count_o=1.
- Glitch pulses of FILTER-1 cycles on ps2_clk while IDLE, plus a stop bit sent as 0 → no push from the glitches; the bad stop bit gives ferr_o=1 for exactly one cycle.
- 9 frames 0x01..0x09 with no reads (depth 8) → count_o=8, ovf_o=1; reads return 0x01..0x08 in order; clr_i → ovf_o=0.
- FIFO full, rd_i asserted in the same cycle the 9th frame (0x09) is pushed → ovf_o stays 0, count_o=8; drained reads return 0x02..0x09.
